cb_addr_seq: RTL and testbench

- Address sequencer directly upstream of the CB address shift stage.
- Walks every state group (robot group 0, then landmarks 1..landmark_num) and every row slot within each group.
- Per cycle it produces the BANK0 row base address (din), the per-stage shift enable mask (en) and the group parity (dir) that the shift stage consumes.
- A start/busy/done handshake ties it to the SLAM top-level controller.

---
 rtl/cb_pkg.sv | 32 +++
 rtl/cb_slot_counter.sv | 70 +++++++
 rtl/cb_addr_seq.sv | 172 +++++++++++++++++
 tb/tb_cb_addr_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cb_pkg.sv
// -----------------------------------------------------------------------------
// cb_pkg
// Shared definitions for the CB address sequencing blocks:
//   - default slot/group geometry (last slot index, group stride, base address)
//   - sequencer FSM state encoding
//   - helper functions: slot counter width and the shift-enable thermometer bit
// -----------------------------------------------------------------------------
package cb_pkg;

    localparam int STATE_CNT_MAX_DEF = 5;
    localparam int GROUP_STRIDE_DEF  = 6;
    localparam int BASE_ADDR_DEF     = 0;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    // Width needed to hold slot indices 0..cnt_max (at least one bit).
    function automatic int slot_w(input int cnt_max);
        return (cnt_max > 0) ? $clog2(cnt_max + 1) : 1;
    endfunction

    // One bit of the shift-enable thermometer: stage 'stage' is enabled once
    // the slot index has passed it, and every stage drops in the last slot of
    // the group so the shift pipeline flushes before the next group starts.
    function automatic logic en_bit(input int slot, input int stage, input int cnt_max);
        return (slot > stage) && (slot < cnt_max);
    endfunction

endpackage

// File: rtl/cb_slot_counter.sv
// -----------------------------------------------------------------------------
// cb_slot_counter
// Nested slot/group counter for the CB address sequencer. The slot counter
// runs 0..STATE_CNT_MAX; on wrap the group counter increments.
//
// Ports:
//   clk        in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   clear      in   load both counters with 0 (sweep start)
//   advance    in   step the counters by one slot (low = hold)
//   lm         in   last group index of the current sweep
//   state_nxt  out  slot index after this clock edge
//   group_nxt  out  group index after this clock edge
//   terminal   out  current slot is the last slot of the last group
// -----------------------------------------------------------------------------
module cb_slot_counter
    import cb_pkg::*;
#(
    parameter int ROW_LEN       = 10,
    parameter int STATE_CNT_MAX = STATE_CNT_MAX_DEF,
    localparam int SLOT_W       = slot_w(STATE_CNT_MAX)
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic               clear,
    input  logic               advance,
    input  logic [ROW_LEN-1:0] lm,
    output logic [SLOT_W-1:0]  state_nxt,
    output logic [ROW_LEN-1:0] group_nxt,
    output logic               terminal
);

    logic [SLOT_W-1:0]  state_cnt;
    logic [ROW_LEN-1:0] group_cnt;
    logic               last_slot;

    assign last_slot = (state_cnt == SLOT_W'(STATE_CNT_MAX));
    assign terminal  = last_slot && (group_cnt == lm);

    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt = state_cnt;
        group_nxt = group_cnt;
        if (clear) begin
            state_nxt = '0;
            group_nxt = '0;
        end else if (advance) begin
            if (last_slot) begin
                state_nxt = '0;
                group_nxt = group_cnt + 1'b1;
            end else begin
                state_nxt = state_cnt + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_cnt <= '0;
            group_cnt <= '0;
        end else begin
            state_cnt <= state_nxt;
            group_cnt <= group_nxt;
        end
    end

endmodule

// File: rtl/cb_addr_seq.sv
// -----------------------------------------------------------------------------
// cb_addr_seq
// Address sequencer feeding the CB address shift stage. On start it sweeps
// group 0 (robot) and landmarks 1..landmark_num, STATE_CNT_MAX+1 slots per
// group, emitting the BANK0 row base address, the shift-enable mask and the
// group parity. All outputs are registered.
//
// Ports:
//   clk           in   system clock
//   sys_rst_n     in   asynchronous active-low reset
//   start         in   sweep request pulse, accepted only when idle
//   hold          in   downstream stall: freezes counters and outputs in RUN
//   landmark_num  in   landmark count, sampled when start is accepted
//   din           out  row base address
//   en            out  shift-enable thermometer mask
//   dir           out  group parity (0 increment mode, 1 pure shift mode)
//   group_cnt     out  current group index
//   valid         out  din/en/dir meaningful
//   busy          out  sweep in progress
//   done          out  one-cycle pulse after the final slot
// -----------------------------------------------------------------------------
module cb_addr_seq
    import cb_pkg::*;
#(
    parameter int              L             = 4,
    parameter int              DW            = 16,
    parameter int              ROW_LEN       = 10,
    parameter int              STATE_CNT_MAX = STATE_CNT_MAX_DEF,
    parameter int              GROUP_STRIDE  = GROUP_STRIDE_DEF,
    parameter logic [DW-1:0]   BASE_ADDR     = DW'(BASE_ADDR_DEF)
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic               hold,
    input  logic [ROW_LEN-1:0] landmark_num,
    output logic [DW-1:0]      din,
    output logic [L-1:0]       en,
    output logic               dir,
    output logic [ROW_LEN-1:0] group_cnt,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    localparam int SLOT_W = slot_w(STATE_CNT_MAX);

    seq_state_e         state_q, state_d;
    logic [ROW_LEN-1:0] lm_q;

    logic               cnt_clear, cnt_adv, lm_load;
    logic               out_run, out_finish, out_idle;

    logic [SLOT_W-1:0]  state_nxt;
    logic [ROW_LEN-1:0] group_nxt;
    logic               terminal;

    logic [DW-1:0]      din_calc;
    logic [L-1:0]       en_calc;

    cb_slot_counter #(
        .ROW_LEN       (ROW_LEN),
        .STATE_CNT_MAX (STATE_CNT_MAX)
    ) u_slot_counter (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .clear     (cnt_clear),
        .advance   (cnt_adv),
        .lm        (lm_q),
        .state_nxt (state_nxt),
        .group_nxt (group_nxt),
        .terminal  (terminal)
    );

    // Output values are computed from the counters' next values so the
    // registered outputs line up with the slot the counters move into.
    assign din_calc = BASE_ADDR + DW'(group_nxt) * DW'(GROUP_STRIDE) + DW'(state_nxt);

    always_comb begin
        en_calc = '0;
        for (int i = 0; i < L; i++) begin
            en_calc[i] = en_bit(int'(state_nxt), i, STATE_CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= SEQ_IDLE;
            lm_q    <= '0;
        end else begin
            state_q <= state_d;
            if (lm_load) begin
                lm_q <= landmark_num;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_clear  = 1'b0;
        cnt_adv    = 1'b0;
        lm_load    = 1'b0;
        out_run    = 1'b0;
        out_finish = 1'b0;
        out_idle   = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    state_d   = SEQ_RUN;
                    cnt_clear = 1'b1;
                    lm_load   = 1'b1;
                    out_run   = 1'b1;
                end else begin
                    out_idle = 1'b1;
                end
            end
            SEQ_RUN: begin
                // With hold high nothing is asserted: counters and output
                // registers all keep their value.
                if (!hold) begin
                    if (terminal) begin
                        state_d    = SEQ_DONE;
                        out_finish = 1'b1;
                    end else begin
                        cnt_adv = 1'b1;
                        out_run = 1'b1;
                    end
                end
            end
            SEQ_DONE: begin
                state_d  = SEQ_IDLE;
                out_idle = 1'b1;
            end
            default: begin
                state_d  = SEQ_IDLE;
                out_idle = 1'b1;
            end
        endcase
    end

    // din/dir/group_cnt keep their last sweep value outside RUN; en is
    // cleared on finish so no shift stage stays enabled while idle.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            din       <= '0;
            en        <= '0;
            dir       <= 1'b0;
            group_cnt <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (out_run) begin
            din       <= din_calc;
            en        <= en_calc;
            dir       <= group_nxt[0];
            group_cnt <= group_nxt;
            valid     <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else if (out_finish) begin
            en        <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
        end else if (out_idle) begin
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cb_addr_seq.sv
// -----------------------------------------------------------------------------
// tb_cb_addr_seq
// Directed testbench for cb_addr_seq. A second instance with BASE_ADDR set
// near the top of the address space covers address wrap-around.
// -----------------------------------------------------------------------------
module tb_cb_addr_seq;

    logic        clk;
    logic        sys_rst_n;
    logic        start, hold;
    logic [9:0]  landmark_num;
    logic [15:0] din;
    logic [3:0]  en;
    logic        dir, valid, busy, done;
    logic [9:0]  group_cnt;

    logic        start_w;
    logic [15:0] din_w;
    logic [3:0]  en_w;
    logic        dir_w, valid_w, busy_w, done_w;
    logic [9:0]  group_cnt_w;

    int n_vec = 0;
    int n_err = 0;

    // Hand-computed mask per slot: thermometer fill, empty in the last slot.
    logic [3:0]  en_tbl   [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};
    logic [15:0] wrap_tbl [6] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};

    cb_addr_seq dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .hold         (hold),
        .landmark_num (landmark_num),
        .din          (din),
        .en           (en),
        .dir          (dir),
        .group_cnt    (group_cnt),
        .valid        (valid),
        .busy         (busy),
        .done         (done)
    );

    cb_addr_seq #(.BASE_ADDR(16'hFFFE)) dut_w (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start_w),
        .hold         (1'b0),
        .landmark_num (10'd0),
        .din          (din_w),
        .en           (en_w),
        .dir          (dir_w),
        .group_cnt    (group_cnt_w),
        .valid        (valid_w),
        .busy         (busy_w),
        .done         (done_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int lm);
        landmark_num = 10'(lm);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs one sweep while checking every valid cycle against the slot model.
    // hold_idx: slot position at which hold is raised for 3 cycles (-1 none).
    // poke_idx: slot position at which start is re-pulsed and landmark_num
    //           changed to 7 (-1 none).
    task automatic run_sweep(input int lm, input int hold_idx, input int poke_idx,
                             input int exp_len);
        int k, g, s, n_valid, n_hold, cyc, k_obs;
        pulse_start(lm);
        k = 0; n_valid = 0; n_hold = 0; cyc = 0;
        while (valid === 1'b1 && cyc < 200) begin
            g = k / 6;
            s = k % 6;
            check("sweep_din", 32'(din), 32'(g * 6 + s));
            check("sweep_en",  32'(en),  32'(en_tbl[s]));
            check("sweep_dir", 32'(dir), 32'(g & 1));
            check("sweep_grp", 32'(group_cnt), 32'(g));
            check("sweep_busy", 32'(busy), 32'd1);
            n_valid++;
            k_obs = k;
            if (k == hold_idx && n_hold < 3) begin
                hold = 1'b1;
                n_hold++;
            end else begin
                hold = 1'b0;
                k++;
            end
            if (k_obs == poke_idx && hold == 1'b0) begin
                start = 1'b1;
                landmark_num = 10'd7;
            end else begin
                start = 1'b0;
            end
            cyc++;
            tick();
        end
        hold  = 1'b0;
        start = 1'b0;
        check("sweep_len",  32'(n_valid), 32'(exp_len));
        check("sweep_done", 32'(done), 32'd1);
        check("sweep_idle_busy", 32'(busy), 32'd0);
        check("sweep_final_grp", 32'(group_cnt), 32'(lm));
        tick();
        check("sweep_done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        sys_rst_n    = 1'b0;
        start        = 1'b0;
        start_w      = 1'b0;
        hold         = 1'b0;
        landmark_num = 10'd0;

        // Reset state
        #12;
        check("rst_din",   32'(din), 32'd0);
        check("rst_en",    32'(en), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        sys_rst_n = 1'b1;
        tick();

        // Hold while idle has no effect; start then proceeds normally.
        hold = 1'b1;
        tick();
        check("idle_hold_valid", 32'(valid), 32'd0);
        hold = 1'b0;

        // Single group, explicit vectors
        pulse_start(0);
        for (int s = 0; s < 6; s++) begin
            check("sg_valid", 32'(valid), 32'd1);
            check("sg_din",   32'(din), 32'(s));
            check("sg_en",    32'(en), 32'(en_tbl[s]));
            check("sg_dir",   32'(dir), 32'd0);
            check("sg_done",  32'(done), 32'd0);
            tick();
        end
        check("sg_done_pulse", 32'(done), 32'd1);
        check("sg_done_valid", 32'(valid), 32'd0);
        check("sg_done_busy",  32'(busy), 32'd0);
        // start coinciding with DONE is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_start_valid", 32'(valid), 32'd0);
        check("done_start_busy",  32'(busy), 32'd0);
        check("done_start_done",  32'(done), 32'd0);
        tick();
        check("done_start_still_idle", 32'(valid), 32'd0);

        // Two landmarks: 18 valid cycles, din at group 2 slot 0 is 12
        run_sweep(2, -1, -1, 18);

        // Hold 3 cycles at group 1 slot 3 (din 9): 12 + 3 valid cycles
        run_sweep(1, 9, -1, 15);

        // Start re-pulsed and landmark_num changed mid-sweep: still 12 cycles
        run_sweep(1, -1, 4, 12);
        landmark_num = 10'd0;

        // Reset mid-sweep at group 1, slot 2
        pulse_start(2);
        for (int i = 0; i < 8; i++) tick();
        check("mid_pre_din", 32'(din), 32'd8);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_din",   32'(din), 32'd0);
        check("mid_rst_en",    32'(en), 32'd0);
        check("mid_rst_dir",   32'(dir), 32'd0);
        check("mid_rst_grp",   32'(group_cnt), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_busy",  32'(busy), 32'd0);
        #2;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_no_done",  32'(done), 32'd0);
            check("mid_rst_no_valid", 32'(valid), 32'd0);
        end
        pulse_start(0);
        check("restart_valid", 32'(valid), 32'd1);
        check("restart_din",   32'(din), 32'd0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("restart_done_seen", 32'(done), 32'd1);
        tick();

        // Address wrap with BASE_ADDR = FFFE
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("wrap_valid", 32'(valid_w), 32'd1);
            check("wrap_din",   32'(din_w), 32'(wrap_tbl[i]));
            tick();
        end
        check("wrap_done", 32'(done_w), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
